// File: rtl/iterative_multiplier_if.sv
// rtl/iterative_multiplier_if.sv - request/result bundle for the iterative multiplier
interface iterative_multiplier_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signedMode;
  logic [WIDTH-1:0] leftOperand;
  logic [WIDTH-1:0] rightOperand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultHigh;
  logic [WIDTH-1:0] resultLow;

  modport master (
    output start, signedMode, leftOperand, rightOperand,
    input  busy, done, resultHigh, resultLow
  );

  modport slave (
    input  start, signedMode, leftOperand, rightOperand,
    output busy, done, resultHigh, resultLow
  );
endinterface

// File: rtl/iterative_multiplier.sv
// rtl/iterative_multiplier.sv - sign-magnitude shift-and-add multiplier retiring STEP bits per cycle
module iterative_multiplier #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  iterative_multiplier_if.slave bus
);
  localparam int CYCLES = WIDTH / STEP;
  localparam int CW     = $clog2(CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state,  w_state_nxt;
  logic [CW-1:0]      r_count,  w_count_nxt;
  logic [2*WIDTH-1:0] r_acc,    w_acc_nxt;
  logic [2*WIDTH-1:0] r_mcand,  w_mcand_nxt;
  logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;
  logic [WIDTH-1:0]   r_hi,     w_hi_nxt;
  logic [WIDTH-1:0]   r_lo,     w_lo_nxt;
  logic               r_neg,    w_neg_nxt;
  logic               r_busy,   w_busy_nxt;
  logic               r_done,   w_done_nxt;

  logic [WIDTH-1:0]   w_left_mag;
  logic [WIDTH-1:0]   w_right_mag;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_prod;

  // Operand magnitudes; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
  always_comb begin
    w_left_mag  = (bus.signedMode && bus.leftOperand[WIDTH-1])  ? -bus.leftOperand  : bus.leftOperand;
    w_right_mag = (bus.signedMode && bus.rightOperand[WIDTH-1]) ? -bus.rightOperand : bus.rightOperand;
  end

  // Partial product for the STEP multiplier bits retired this cycle, plus the sign-restored final product
  always_comb begin
    w_addend = '0;
    for (int i = 0; i < STEP; i++) begin
      if (r_mplier[i]) begin
        w_addend = w_addend + (r_mcand << i);
      end
    end
    w_prod = r_neg ? -r_acc : r_acc;
  end

  // Next-state and next-register values for IDLE/RUN/FIX
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    w_neg_nxt    = r_neg;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_mcand_nxt  = {{WIDTH{1'b0}}, w_left_mag};
          w_mplier_nxt = w_right_mag;
          w_neg_nxt    = bus.signedMode & (bus.leftOperand[WIDTH-1] ^ bus.rightOperand[WIDTH-1]);
          w_acc_nxt    = '0;
          w_count_nxt  = CW'(CYCLES);
          w_busy_nxt   = 1'b1;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
        w_acc_nxt    = r_acc + w_addend;
        w_mcand_nxt  = r_mcand << STEP;
        w_mplier_nxt = r_mplier >> STEP;
        w_count_nxt  = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_hi_nxt    = w_prod[2*WIDTH-1:WIDTH];
        w_lo_nxt    = w_prod[WIDTH-1:0];
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
      r_neg    <= w_neg_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.resultHigh = r_hi;
  assign bus.resultLow  = r_lo;
endmodule

// File: doc/iterative_multiplier.md
ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter STEP, default 1: multiplier bits retired per cycle; legal values 1, 2, 4; SHALL divide WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a multiplication; sampled only while idle.
REQ-006 SHALL have port signedMode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port leftOperand  input  WIDTH  multiplicand; sampled with start.
REQ-008 SHALL have port rightOperand  input  WIDTH  multiplier; sampled with start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result registers update.
REQ-011 SHALL have port resultHigh  output  WIDTH  upper WIDTH bits of the 2*WIDTH-bit product.
REQ-012 SHALL have port resultLow  output  WIDTH  lower WIDTH bits of the product.

Function
REQ-013 SHALL implement states IDLE, RUN and FIX; all outputs registered.
REQ-014 In IDLE with start=1 at an edge, SHALL latch the operands and signedMode, assert busy, load cycle counter = WIDTH/STEP, and enter RUN.
REQ-015 In signed mode, SHALL latch operand magnitudes and record productNegative = sign(left) XOR sign(right); magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held unsigned.
REQ-016 Each RUN cycle SHALL perform shift-and-add of STEP multiplier bits into a 2*WIDTH-bit accumulator and decrement the counter; after the last step SHALL enter FIX.
REQ-017 In FIX, SHALL two's-complement negate the accumulator if productNegative, load resultHigh/resultLow, deassert busy, pulse done, and return to IDLE, all on the same edge.
REQ-018 Latency: start accepted at edge E0 SHALL yield done=1 and valid results from edge E0+WIDTH/STEP+1 for exactly one cycle (33 cycles at the defaults).
REQ-019 start while busy=1 SHALL be ignored, with no effect on operands, counter or result.
REQ-020 start during the done cycle (busy=0) SHALL be accepted, permitting back-to-back operations.
REQ-021 resultHigh/resultLow SHALL hold their value from done until the next done; they SHALL NOT change during RUN.
REQ-022 The product SHALL be exact modulo 2^(2*WIDTH) for all operand pairs, including 0, all-ones and -2^(WIDTH-1) x -2^(WIDTH-1).
REQ-023 signedMode SHALL affect only the operation in which it was latched.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, busy=0, done=0, resultHigh=0, resultLow=0, counter=0 and accumulator=0, independent of clk.
REQ-025 reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-026 Unsigned, WIDTH=32, STEP=1: 0xFFFFFFFF x 0xFFFFFFFF -> resultHigh=0xFFFFFFFE, resultLow=0x00000001, done exactly 33 cycles after start.
REQ-027 Signed: 0xFFFFFFFF (-1) x 0x00000005 -> resultHigh=0xFFFFFFFF, resultLow=0xFFFFFFFB.
REQ-028 Signed: 0x80000000 x 0x80000000 -> resultHigh=0x40000000, resultLow=0x00000000; same operands unsigned -> resultHigh=0x40000000, resultLow=0x00000000.
REQ-029 start=1 with 3 x 4, then start=1 with 9 x 9 ten cycles later -> single done with resultLow=12; second request ignored.
REQ-030 reset pulsed 15 cycles into 7 x 7 -> busy=0 and results=0 immediately, no done; subsequent 2 x 3 -> resultLow=6 after 33 cycles.
REQ-031 STEP=4: unsigned 7 x 6 -> resultLow=42 after 9 cycles; new start in the done cycle with 5 x 5 -> resultLow=25 nine cycles later.
